pwm_duty_ctrl: RTL and testbench
================================

# pwm_duty_ctrl

Duty-cycle controller for the 10-step PWM generator. It debounces the increase/decrease push buttons and accepts direct duty loads from a host. It holds the target duty in a bounded register and commits it to the PWM datapath only at a PWM period boundary, so no output period is ever truncated. It sits between the `ui_in` button pins and the PWM counter/comparator in `tt_um_Ziyi_Yuchen`.

## Interface

Parameters:
- `DUTY_W`, 4: width of the duty value.
- `DUTY_MIN`, 1: lowest duty step that buttons and loads can reach.
- `DUTY_MAX`, 9: highest duty step that buttons and loads can reach.
- `DUTY_RST`, 5: duty value after reset (50 %).
- `TICK_DIV`, 25000000: slow-tick divisor for debounce. Use 2 for simulation.

Ports:
- `clk` in 1: single clock. All state is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `btn_inc` in 1: raw increase button, asynchronous and bouncy.
- `btn_dec` in 1: raw decrease button, asynchronous and bouncy.
- `ld_valid` in 1: host load request.
- `ld_duty` in `DUTY_W`: host load value.
- `ld_ready` out 1: load is accepted when `ld_valid & ld_ready`.
- `pwm_wrap` in 1: one-cycle pulse from the PWM counter when it returns to 0, i.e. a period start.
- `ramp_mode` in 1: selects automatic triangle sweep. Used only when the ramp feature is compiled in.
- `duty_out` out `DUTY_W`: committed duty, fed to the PWM comparator.
- `duty_pending` out 1: target differs from the committed value and awaits `pwm_wrap`.
- `at_max` out 1: target == `DUTY_MAX`.
- `at_min` out 1: target == `DUTY_MIN`.

## Operation

- **Tick counter:** counts 0..`TICK_DIV`-1 and wraps. `tick` is high for the one cycle in which the count equals `TICK_DIV`-1.
- **Debounce, per button:** two flops, s1 and s2, both enabled by `tick`; s1 <= btn, s2 <= s1. The press event is `s1 & ~s2 & tick`, one cycle wide, and there is exactly one event per press.
- **Target register update,** evaluated in priority order each cycle:
  1. Load accepted: target <= `ld_duty` clamped to [`DUTY_MIN`, `DUTY_MAX`]. Any button events in the same cycle are dropped.
  2. inc and dec events in the same cycle: they cancel; target is unchanged.
  3. inc event: target+1 if target < `DUTY_MAX`, else unchanged (saturate, no wrap).
  4. dec event: target-1 if target > `DUTY_MIN`, else unchanged.
- `duty_pending` is set on any cycle in which the target actually changes to a value different from `duty_out`.
- **Commit:** on a cycle with `pwm_wrap=1` and `duty_pending=1`, `duty_out` <= the target value held in that cycle.
  - After the commit, `duty_pending` clears unless the target is also changing in that same cycle; in that case it stays set and the new value is committed at the next wrap.
- **Load handshake:** `ld_ready = ~duty_pending & ~ramp_active`. At most one load is in flight per PWM period. The host must hold `ld_valid` until it sees `ld_ready`.

## Timing

- **Reset:**
  - Target and `duty_out` = `DUTY_RST`.
  - `duty_pending`=0, `ld_ready`=1, `at_max`=0, `at_min`=0.
  - Tick counter = 0, s1 = s2 = 0, ramp direction = up.
- **Reset mid-operation:** the pending value is discarded and there is no commit. Reset wins over `pwm_wrap` in the same cycle.
- **Button latency:** the target changes at the edge after the event cycle. The worst-case press-to-event delay is 2·`TICK_DIV` cycles.
- **Commit latency:** `duty_out` changes at the edge that samples `pwm_wrap`. It is visible to the comparator from that period's count 0.
- **Load latency:** the target updates at the accepting edge, and `ld_ready` drops in the next cycle.
- A `pwm_wrap` pulse with no pending value leaves `duty_out` unchanged.

## Configuration

- Macro: `PWM_DUTY_RAMP_EN`.
- **Defined:** when `ramp_mode=1` (ramp_active), the target steps by ±1 on each `tick` as a triangle sweep, DUTY_MIN→DUTY_MAX→DUTY_MIN.
  - Direction flips when an endpoint is reached, so each endpoint is held for one tick only.
  - Buttons and loads are ignored, and `ld_ready`=0.
  - When `ramp_mode` is deasserted, the current target is kept.
- **Undefined:** `ramp_mode` is ignored, there is no direction flop, and `ramp_active` is constant 0.

## Test plan

- **Reset and first commit (`TICK_DIV`=2):** apply `rst` → `duty_out`=5, `ld_ready`=1. Pulse `pwm_wrap` → `duty_out` stays 5.
- **Single inc press:** hold `btn_inc` high for 8 cycles → exactly one target step to 6 and `duty_pending`=1. The next `pwm_wrap` → `duty_out`=6 and `duty_pending`=0.
- **Saturation:** 6 inc presses from 5 → target 9 and `at_max`=1. 10 dec presses from 9 → target 1 and `at_min`=1; no wrap to 0 or 15.
- **Load clamp and priority:**
  - `ld_duty`=12 together with an inc event in the same cycle → target 9; the inc is dropped.
  - `ld_ready`=0 until `pwm_wrap`; a second `ld_valid` is held off until the commit.
- **Simultaneous inc/dec events, and an event on the wrap cycle:**
  - Both inc and dec events in one cycle → no change.
  - With target 6 pending, a dec event on the `pwm_wrap` cycle → `duty_out`=6, target 5, `duty_pending` stays 1.
- **Ramp (with `PWM_DUTY_RAMP_EN`):** `ramp_mode`=1 from target 5 → per-tick target sequence 6,7,8,9,8,…,1,2. Buttons have no effect and `ld_ready`=0.

Source files
------------

// File: rtl/pwm_duty_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module   : pwm_duty_ctrl                                                 |
// | Purpose  : Debounced button / host-load duty controller that commits the |
// |            target duty to the PWM datapath only on a period boundary.    |
// | Option   : PWM_DUTY_RAMP_EN adds an automatic triangle sweep (ramp_mode). |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module pwm_duty_ctrl #(
  parameter int DUTY_W   = 4,
  parameter int DUTY_MIN = 1,
  parameter int DUTY_MAX = 9,
  parameter int DUTY_RST = 5,
  parameter int TICK_DIV = 25000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_inc,
  input  logic              btn_dec,
  input  logic              ld_valid,
  input  logic [DUTY_W-1:0] ld_duty,
  output logic              ld_ready,
  input  logic              pwm_wrap,
  input  logic              ramp_mode,
  output logic [DUTY_W-1:0] duty_out,
  output logic              duty_pending,
  output logic              at_max,
  output logic              at_min
);

  localparam int                   c_tick_w    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_tick_w-1:0]  c_tick_last = c_tick_w'(TICK_DIV - 1);
  localparam logic [DUTY_W-1:0]    c_min       = DUTY_W'(DUTY_MIN);
  localparam logic [DUTY_W-1:0]    c_max       = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0]    c_rst       = DUTY_W'(DUTY_RST);

  logic [c_tick_w-1:0] r_tick_cnt;
  logic                w_tick;
  logic [1:0]          r_inc_sync;   // [0] = s1, [1] = s2
  logic [1:0]          r_dec_sync;
  logic                w_inc_evt;
  logic                w_dec_evt;
  logic [DUTY_W-1:0]   r_target;
  logic [DUTY_W-1:0]   r_duty;
  logic                r_pending;
  logic [DUTY_W-1:0]   w_target_nxt;
  logic [DUTY_W-1:0]   w_duty_nxt;
  logic [DUTY_W-1:0]   w_ld_clamped;
  logic                w_ld_fire;
  logic                w_ramp_active;
  logic [DUTY_W-1:0]   w_ramp_target;

  assign w_tick = (r_tick_cnt == c_tick_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // Slow-tick sampling rejects bounce; rising edge of s1 vs s2 gives one event per press.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inc_sync <= 2'b00;
      r_dec_sync <= 2'b00;
    end else if (w_tick) begin
      r_inc_sync <= {r_inc_sync[0], btn_inc};
      r_dec_sync <= {r_dec_sync[0], btn_dec};
    end
  end

  assign w_inc_evt = r_inc_sync[0] & ~r_inc_sync[1] & w_tick;
  assign w_dec_evt = r_dec_sync[0] & ~r_dec_sync[1] & w_tick;

`ifdef PWM_DUTY_RAMP_EN
  logic r_ramp_up;
  logic w_ramp_step_up;

  assign w_ramp_active = ramp_mode;

  // Reverse at an endpoint (or if entered beyond one) so endpoints last one tick.
  always_comb begin
    w_ramp_step_up = r_ramp_up ? (r_target < c_max) : ~(r_target > c_min);
    w_ramp_target  = w_ramp_step_up ? (r_target + 1'b1) : (r_target - 1'b1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ramp_up <= 1'b1;
    end else if (w_ramp_active && w_tick) begin
      if (w_ramp_target == c_max) begin
        r_ramp_up <= 1'b0;
      end else if (w_ramp_target == c_min) begin
        r_ramp_up <= 1'b1;
      end else begin
        r_ramp_up <= w_ramp_step_up;
      end
    end
  end
`else
  logic w_unused_ramp;

  assign w_ramp_active = 1'b0;
  assign w_ramp_target = r_target;
  assign w_unused_ramp = ramp_mode;
`endif

  assign w_ld_fire    = ld_valid & ld_ready;
  assign w_ld_clamped = (ld_duty < c_min) ? c_min :
                        (ld_duty > c_max) ? c_max : ld_duty;

  always_comb begin
    w_target_nxt = r_target;
    if (w_ramp_active) begin
      if (w_tick) begin
        w_target_nxt = w_ramp_target;
      end
    end else if (w_ld_fire) begin
      w_target_nxt = w_ld_clamped;
    end else if (w_inc_evt && w_dec_evt) begin
      w_target_nxt = r_target;
    end else if (w_inc_evt) begin
      if (r_target < c_max) begin
        w_target_nxt = r_target + 1'b1;
      end
    end else if (w_dec_evt) begin
      if (r_target > c_min) begin
        w_target_nxt = r_target - 1'b1;
      end
    end
  end

  assign w_duty_nxt = (pwm_wrap && r_pending) ? r_target : r_duty;

  // Pending tracks "target differs from committed"; a change on the commit cycle stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_target  <= c_rst;
      r_duty    <= c_rst;
      r_pending <= 1'b0;
    end else begin
      r_target  <= w_target_nxt;
      r_duty    <= w_duty_nxt;
      r_pending <= (w_target_nxt != w_duty_nxt);
    end
  end

  assign duty_out     = r_duty;
  assign duty_pending = r_pending;
  assign ld_ready     = ~r_pending & ~w_ramp_active;
  assign at_max       = (r_target == c_max);
  assign at_min       = (r_target == c_min);

endmodule

`default_nettype wire

// File: tb/tb_pwm_duty_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_pwm_duty_ctrl                                              |
// | Purpose  : Directed + randomized bench for pwm_duty_ctrl with a          |
// |            behavioural duty model.                                       |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pwm_duty_ctrl;

  localparam int DW   = 4;
  localparam int DMIN = 1;
  localparam int DMAX = 9;
  localparam int DRST = 5;
  localparam int TD   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          btn_inc;
  logic          btn_dec;
  logic          ld_valid;
  logic [DW-1:0] ld_duty;
  logic          ld_ready;
  logic          pwm_wrap;
  logic          ramp_mode;
  logic [DW-1:0] duty_out;
  logic          duty_pending;
  logic          at_max;
  logic          at_min;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: target/committed duty, cycles since reset, button samples per tick.
  int m_target;
  int m_duty;
  int m_k;
  bit m_up;
  bit h_inc[$];
  bit h_dec[$];

  always #5 clk = ~clk;

  pwm_duty_ctrl #(
    .DUTY_W   (DW),
    .DUTY_MIN (DMIN),
    .DUTY_MAX (DMAX),
    .DUTY_RST (DRST),
    .TICK_DIV (TD)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .btn_inc      (btn_inc),
    .btn_dec      (btn_dec),
    .ld_valid     (ld_valid),
    .ld_duty      (ld_duty),
    .ld_ready     (ld_ready),
    .pwm_wrap     (pwm_wrap),
    .ramp_mode    (ramp_mode),
    .duty_out     (duty_out),
    .duty_pending (duty_pending),
    .at_max       (at_max),
    .at_min       (at_min)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp(input int v);
    return (v < DMIN) ? DMIN : (v > DMAX) ? DMAX : v;
  endfunction

  function automatic bit ramp_on();
`ifdef PWM_DUTY_RAMP_EN
    return ramp_mode;
`else
    return 1'b0;
`endif
  endfunction

  // Advance model and DUT one clock with the currently driven inputs, then compare.
  task automatic step();
    int  nt;
    int  nd;
    bit  tick;
    bit  ei;
    bit  ed;
    bit  rmp;
    rmp = ramp_on();
    if (rst) begin
      nt = DRST; nd = DRST; m_k = 0; m_up = 1'b1;
      h_inc = '{1'b0, 1'b0};
      h_dec = '{1'b0, 1'b0};
    end else begin
      tick = ((m_k % TD) == TD - 1);
      ei   = tick && h_inc[$] && !h_inc[$-1];
      ed   = tick && h_dec[$] && !h_dec[$-1];
      if (tick) begin
        h_inc.push_back(btn_inc);
        h_dec.push_back(btn_dec);
        if (h_inc.size() > 3) h_inc.delete(0);
        if (h_dec.size() > 3) h_dec.delete(0);
      end
      nt = m_target;
      if (rmp) begin
        if (tick) begin
          if (m_up && nt < DMAX)       nt = nt + 1;
          else if (!m_up && nt > DMIN) nt = nt - 1;
          else if (m_up)               nt = nt - 1;
          else                         nt = nt + 1;
          if (nt == DMAX)      m_up = 1'b0;
          else if (nt == DMIN) m_up = 1'b1;
          else                 m_up = (nt > m_target);
        end
      end else if (ld_valid && (m_target == m_duty)) begin
        nt = clamp(int'(ld_duty));
      end else if (ei && !ed) begin
        nt = (nt < DMAX) ? nt + 1 : nt;
      end else if (ed && !ei) begin
        nt = (nt > DMIN) ? nt - 1 : nt;
      end
      nd = (pwm_wrap && m_target != m_duty) ? m_target : m_duty;
      m_k++;
    end
    @(posedge clk);
    #1;
    m_target = nt;
    m_duty   = nd;
    rmp      = ramp_on();
    check("duty_out", 32'(duty_out), 32'(m_duty));
    check("duty_pending", 32'(duty_pending), 32'(m_target != m_duty));
    check("ld_ready", 32'(ld_ready), 32'((m_target == m_duty) && !rmp));
    check("at_max", 32'(at_max), 32'(m_target == DMAX));
    check("at_min", 32'(at_min), 32'(m_target == DMIN));
  endtask

  task automatic press(input bit inc, input bit dec);
    btn_inc = inc; btn_dec = dec;
    repeat (6) step();
    btn_inc = 1'b0; btn_dec = 1'b0;
    repeat (6) step();
  endtask

  task automatic wrap();
    pwm_wrap = 1'b1;
    step();
    pwm_wrap = 1'b0;
  endtask

  initial begin
    rst = 1'b1; btn_inc = 1'b0; btn_dec = 1'b0; ld_valid = 1'b0;
    ld_duty = '0; pwm_wrap = 1'b0; ramp_mode = 1'b0;
    m_target = DRST; m_duty = DRST; m_k = 0; m_up = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    check("reset_duty", 32'(duty_out), 32'd5);
    check("reset_ld_ready", 32'(ld_ready), 32'd1);
    wrap();
    check("idle_wrap_duty", 32'(duty_out), 32'd5);

    // Long single press yields one step.
    btn_inc = 1'b1;
    repeat (8) step();
    btn_inc = 1'b0;
    repeat (4) step();
    check("single_inc_pending", 32'(duty_pending), 32'd1);
    wrap();
    check("single_inc_commit", 32'(duty_out), 32'd6);

    repeat (6) press(1'b1, 1'b0);
    check("sat_max", 32'(at_max), 32'd1);
    wrap();
    check("sat_max_duty", 32'(duty_out), 32'd9);
    repeat (10) press(1'b0, 1'b1);
    check("sat_min", 32'(at_min), 32'd1);
    wrap();
    check("sat_min_duty", 32'(duty_out), 32'd1);
    press(1'b1, 1'b1);
    check("inc_dec_cancel", 32'(duty_pending), 32'd0);

    // Over-range load clamps; second load held off until the commit.
    ld_valid = 1'b1; ld_duty = 4'd12;
    repeat (3) step();
    check("load_hold_off", 32'(ld_ready), 32'd0);
    wrap();
    check("load_clamp_commit", 32'(duty_out), 32'd9);
    ld_duty = 4'd0;
    step();
    ld_valid = 1'b0;
    wrap();
    check("load_low_clamp", 32'(duty_out), 32'd1);

    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      pwm_wrap  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 6) == 0) btn_inc = ~btn_inc;
      if ($urandom_range(0, 6) == 0) btn_dec = ~btn_dec;
      if ($urandom_range(0, 99) == 0) ramp_mode = ~ramp_mode;
      ld_valid  = ($urandom_range(0, 9) == 0);
      ld_duty   = DW'($urandom_range(0, 15));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
